painterengine_gpu_writer_arbiter: RTL and testbench

PAINTERENGINE_GPU_WRITER_ARBITER -- requirements
Module: painterengine_gpu_writer_arbiter

---
 rtl/painterengine_gpu_pkg.sv | 22 ++
 rtl/painterengine_gpu_rr_picker.sv | 30 +++
 rtl/painterengine_gpu_writer_arbiter.sv | 155 +++++++++++++++
 tb/tb_painterengine_gpu_writer_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/painterengine_gpu_pkg.sv
// Shared GPU package: channel count, error codes and
// writer-arbiter state encodings used by the DMA blocks.
package painterengine_gpu_pkg;

  localparam int         GPU_CHANNELS = 4;
  localparam logic [2:0] ERR_TIMEOUT  = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARM      = 3'd1,
    ST_RUN      = 3'd2,
    ST_COMPLETE = 3'd3,
    ST_RELEASE  = 3'd4
  } arb_state_e;

  function automatic logic [GPU_CHANNELS-1:0] ch_onehot(
    input logic [1:0] idx
  );
    ch_onehot = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/painterengine_gpu_rr_picker.sv
// Combinational 4-way round-robin picker; searches upward
// starting one past the last served channel.
module painterengine_gpu_rr_picker
  import painterengine_gpu_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [3:0] grant,
  output logic [1:0] index
);

  logic       found;
  logic [1:0] cand;

  // first requesting channel after last, wrapping mod 4
  always_comb begin
    found = 1'b0;
    index = last;
    cand  = last;
    for (int i = 1; i <= GPU_CHANNELS; i++) begin
      cand = last + 2'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
    grant = found ? ch_onehot(index) : 4'b0000;
  end

endmodule

// File: rtl/painterengine_gpu_writer_arbiter.sv
// Arbitrates four job requesters onto one DMA writer:
// grant, arm (writer held in reset), run, report, release.
module painterengine_gpu_writer_arbiter
  import painterengine_gpu_pkg::*;
#(
  parameter logic [31:0] PARAM_TIMEOUT    = 32'd65535,
  parameter int          PARAM_ARM_CYCLES = 2
) (
  input  logic        i_wire_clock,
  input  logic        i_wire_resetn,
  input  logic [3:0]  i_wire_req,
  output logic [3:0]  o_wire_ack,
  output logic [3:0]  o_wire_err,
  output logic [2:0]  o_wire_err_type,
  output logic        o_wire_busy,
  output logic [3:0]  o_wire_grant,
  output logic [15:0] o_wire_job_count,
  output logic [3:0]  o_wire_router,
  output logic        o_wire_writer_resetn,
  input  logic        i_wire_writer_done,
  input  logic        i_wire_writer_error,
  input  logic [2:0]  i_wire_writer_error_type
);

  localparam logic [15:0] ARM_LAST = 16'(PARAM_ARM_CYCLES - 1);

  arb_state_e  state_q, state_d;
  logic [1:0]  last_q, last_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  grant_q, grant_d;
  logic [3:0]  router_q, router_d;
  logic        wr_rstn_q, wr_rstn_d;
  logic [3:0]  ack_q, ack_d;
  logic [3:0]  err_q, err_d;
  logic [2:0]  type_q, type_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] wdog_q, wdog_d;
  logic [15:0] arm_q, arm_d;

  logic [3:0]  pick_grant;
  logic [1:0]  pick_idx;

  painterengine_gpu_rr_picker u_picker (
    .req   (i_wire_req),
    .last  (last_q),
    .grant (pick_grant),
    .index (pick_idx)
  );

  // next state, job result and registered output values
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    idx_d   = idx_q;
    grant_d = grant_q;
    wdog_d  = wdog_q;
    arm_d   = arm_q;
    cnt_d   = cnt_q;
    ack_d   = 4'b0000;
    err_d   = 4'b0000;
    type_d  = 3'b000;
    unique case (state_q)
      ST_IDLE: begin
        if (|i_wire_req) begin
          state_d = ST_ARM;
          grant_d = pick_grant;
          idx_d   = pick_idx;
          arm_d   = '0;
        end
      end
      ST_ARM: begin
        if (arm_q == ARM_LAST) begin
          state_d = ST_RUN;
          wdog_d  = '0;
        end else begin
          arm_d = arm_q + 16'd1;
        end
      end
      ST_RUN: begin
        wdog_d = wdog_q + 32'd1;
        if (i_wire_writer_error) begin
          err_d  = grant_q;
          type_d = i_wire_writer_error_type;
        end else if (i_wire_writer_done) begin
          ack_d = grant_q;
        end else if (wdog_d == PARAM_TIMEOUT) begin
          err_d  = grant_q;
          type_d = ERR_TIMEOUT;
        end
        if (|ack_d || |err_d) begin
          state_d = ST_COMPLETE;
          cnt_d   = cnt_q + 16'd1;
          last_d  = idx_q;
        end
      end
      ST_COMPLETE: begin
        state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!i_wire_req[idx_q]) begin
          state_d = ST_IDLE;
          grant_d = 4'b0000;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 4'b0000;
      end
    endcase
    router_d  = (state_d == ST_ARM || state_d == ST_RUN)
              ? grant_d : 4'b0000;
    wr_rstn_d = (state_d == ST_RUN);
  end

  // state and output registers, async active-low reset
  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state_q   <= ST_IDLE;
      last_q    <= 2'd3;
      idx_q     <= 2'd0;
      grant_q   <= 4'b0000;
      router_q  <= 4'b0000;
      wr_rstn_q <= 1'b0;
      ack_q     <= 4'b0000;
      err_q     <= 4'b0000;
      type_q    <= 3'b000;
      cnt_q     <= 16'd0;
      wdog_q    <= 32'd0;
      arm_q     <= 16'd0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      idx_q     <= idx_d;
      grant_q   <= grant_d;
      router_q  <= router_d;
      wr_rstn_q <= wr_rstn_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      type_q    <= type_d;
      cnt_q     <= cnt_d;
      wdog_q    <= wdog_d;
      arm_q     <= arm_d;
    end
  end

  assign o_wire_ack           = ack_q;
  assign o_wire_err           = err_q;
  assign o_wire_err_type      = type_q;
  assign o_wire_job_count     = cnt_q;
  assign o_wire_router        = router_q;
  assign o_wire_writer_resetn = wr_rstn_q;
  assign o_wire_busy          = (state_q != ST_IDLE);
  assign o_wire_grant         = (state_q == ST_IDLE) ? 4'b0000 : grant_q;

endmodule

// File: tb/tb_painterengine_gpu_writer_arbiter.sv
// Bench for the GPU writer arbiter: job-timeline model checked
// every cycle, directed scenarios, then random traffic.
module tb_painterengine_gpu_writer_arbiter;

  localparam int T = 16;
  localparam int A = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic        done = 1'b0;
  logic        werr = 1'b0;
  logic [2:0]  wtype = 3'b000;

  logic [3:0]  ack, err, grant, router;
  logic [2:0]  etype;
  logic        busy, wrn;
  logic [15:0] cnt;

  painterengine_gpu_writer_arbiter #(
    .PARAM_TIMEOUT    (32'd16),
    .PARAM_ARM_CYCLES (2)
  ) u_dut (
    .i_wire_clock             (clk),
    .i_wire_resetn            (rst_n),
    .i_wire_req               (req),
    .o_wire_ack               (ack),
    .o_wire_err               (err),
    .o_wire_err_type          (etype),
    .o_wire_busy              (busy),
    .o_wire_grant             (grant),
    .o_wire_job_count         (cnt),
    .o_wire_router            (router),
    .o_wire_writer_resetn     (wrn),
    .i_wire_writer_done       (done),
    .i_wire_writer_error      (werr),
    .i_wire_writer_error_type (wtype)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] oh(input int c);
    logic [3:0] v;
    v = 4'b0000;
    v[c] = 1'b1;
    return v;
  endfunction

  // job timeline model: m_age = cycle index inside the job
  // (1..A arming, A+1.. running), then a report cycle, then
  // waiting for the owner to drop its request.
  int          m_age = 0;
  bit          m_cmp = 0;
  bit          m_rel = 0;
  int          m_last = 3;
  int          m_ch = 0;
  logic [15:0] m_cnt = 0;
  logic [3:0]  e_ack = 0, e_err = 0;
  logic [2:0]  e_type = 0;
  bit          found;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_age = 0; m_cmp = 0; m_rel = 0;
      m_last = 3; m_ch = 0; m_cnt = 0;
      e_ack = 0; e_err = 0; e_type = 0;
    end else begin
      e_ack = 0; e_err = 0; e_type = 0;
      if (m_cmp) begin
        m_cmp = 0;
        m_rel = 1;
      end else if (m_rel) begin
        if (!req[m_ch]) m_rel = 0;
      end else if (m_age == 0) begin
        if (req != 0) begin
          found = 0;
          for (int k = 1; k <= 4; k++)
            if (!found && req[(m_last + k) % 4]) begin
              found = 1;
              m_ch = (m_last + k) % 4;
            end
          m_age = 1;
        end
      end else if (m_age <= A) begin
        m_age++;
      end else begin
        if (werr) begin
          e_err = oh(m_ch); e_type = wtype;
        end else if (done) begin
          e_ack = oh(m_ch);
        end else if (m_age - A == T) begin
          e_err = oh(m_ch); e_type = 3'b111;
        end
        if (e_ack != 0 || e_err != 0) begin
          m_age = 0; m_cmp = 1; m_cnt++; m_last = m_ch;
        end else begin
          m_age++;
        end
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    logic eb;
    eb = (m_age > 0) || m_cmp || m_rel;
    chk("busy", 16'(busy), 16'(eb));
    chk("grant", 16'(grant), 16'(eb ? oh(m_ch) : 4'b0));
    chk("router", 16'(router), 16'(m_age > 0 ? oh(m_ch) : 4'b0));
    chk("writer_resetn", 16'(wrn), 16'(m_age > A));
    chk("ack", 16'(ack), 16'(e_ack));
    chk("err", 16'(err), 16'(e_err));
    chk("job_count", cnt, m_cnt);
    if (e_err != 0) chk("err_type", 16'(etype), 16'(e_type));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    req = 0; done = 0; werr = 0; wtype = 0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_run();
    int n;
    n = 0;
    while (!wrn && n < 30) begin
      tick();
      n++;
    end
    if (!wrn) chk("wait_run_bound", 16'(wrn), 16'd1);
  endtask

  int pend [4];

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_grant", 16'(grant), 16'd0);
    chk("rst_router", 16'(router), 16'd0);
    chk("rst_wrn", 16'(wrn), 16'd0);
    chk("rst_count", cnt, 16'd0);

    // single request on channel 2, arm timing
    req = 4'b0100;
    tick();
    chk("arm1_router", 16'(router), 16'h4);
    chk("arm1_wrn", 16'(wrn), 16'd0);
    chk("arm1_grant", 16'(grant), 16'h4);
    tick();
    chk("arm2_router", 16'(router), 16'h4);
    chk("arm2_wrn", 16'(wrn), 16'd0);
    tick();
    chk("run_wrn", 16'(wrn), 16'd1);
    chk("run_router", 16'(router), 16'h4);
    done = 1;
    tick();
    done = 0;
    chk("ch2_ack", 16'(ack), 16'h4);
    chk("ch2_count", cnt, 16'd1);
    chk("ch2_cmp_wrn", 16'(wrn), 16'd0);
    req = 0;
    tick();
    chk("ch2_ack_once", 16'(ack), 16'd0);
    tick();
    chk("ch2_idle_grant", 16'(grant), 16'd0);

    // all four requesting: rotation 0,1,2,3,0
    do_reset();
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_run();
      chk("rr_grant", 16'(grant), 16'(oh(j % 4)));
      done = 1;
      tick();
      done = 0;
      chk("rr_ack", 16'(ack), 16'(oh(j % 4)));
      chk("rr_count", cnt, 16'(j + 1));
      req[j % 4] = 1'b0;
      tick();
      tick();
      req = 4'b1111;
    end

    // done and error together: error wins
    do_reset();
    req = 4'b0001;
    wait_run();
    done = 1; werr = 1; wtype = 3'b011;
    tick();
    done = 0; werr = 0; wtype = 0;
    chk("de_err", 16'(err), 16'h1);
    chk("de_type", 16'(etype), 16'h3);
    chk("de_ack", 16'(ack), 16'h0);

    // watchdog with a silent writer
    req = 0;
    tick();
    tick();
    req = 4'b0001;
    wait_run();
    repeat (15) tick();
    chk("wd_still_run", 16'(wrn), 16'd1);
    chk("wd_no_err_yet", 16'(err), 16'd0);
    tick();
    chk("wd_err", 16'(err), 16'h1);
    chk("wd_type", 16'(etype), 16'h7);
    chk("wd_wrn", 16'(wrn), 16'd0);
    req = 0;
    tick();
    chk("wd_after_wrn", 16'(wrn), 16'd0);
    tick();

    // owner keeps request high after ack: stay in release
    req = 4'b0010;
    wait_run();
    done = 1;
    tick();
    done = 0;
    chk("rel_ack", 16'(ack), 16'h2);
    req = 4'b0011;
    repeat (4) tick();
    chk("rel_busy", 16'(busy), 16'd1);
    chk("rel_grant", 16'(grant), 16'h2);
    chk("rel_router", 16'(router), 16'd0);
    req = 4'b0001;
    tick();
    chk("rel_idle_busy", 16'(busy), 16'd0);
    chk("rel_idle_grant", 16'(grant), 16'd0);
    tick();
    chk("rel_next_grant", 16'(grant), 16'h1);

    // reset in the middle of a channel-2 job
    do_reset();
    req = 4'b0100;
    wait_run();
    chk("mr_grant", 16'(grant), 16'h4);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mr_busy", 16'(busy), 16'd0);
    chk("mr_grant0", 16'(grant), 16'd0);
    chk("mr_router", 16'(router), 16'd0);
    chk("mr_wrn", 16'(wrn), 16'd0);
    chk("mr_ack", 16'(ack), 16'd0);
    chk("mr_err", 16'(err), 16'd0);
    chk("mr_count", cnt, 16'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    req = 4'b0101;
    @(posedge clk);
    #1;
    chk("mr_next_grant", 16'(grant), 16'h1);

    // random traffic
    do_reset();
    for (int c = 0; c < 4; c++) pend[c] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < 4; c++) begin
        if (ack[c] || err[c]) begin
          pend[c] = int'($urandom_range(1, 4));
        end
        if (pend[c] > 0) begin
          pend[c]--;
          if (pend[c] == 0) req[c] = 1'b0;
        end else if (!req[c]) begin
          if ($urandom_range(0, 5) == 0) req[c] = 1'b1;
        end else if ($urandom_range(0, 99) == 0) begin
          req[c] = 1'b0;
        end
      end
      done  = wrn && ($urandom_range(0, 9) == 0);
      werr  = ($urandom_range(0, 29) == 0);
      wtype = 3'($urandom_range(0, 7));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
